apu_frame_sequencer: RTL and testbench

- Timing and length-control scheduler for the sound channels.
- Divides ac97_bitclk down to the 512 Hz frame-sequencer rate and runs the 8-step frame sequence.
- Emits single-cycle length, sweep and envelope enable pulses to the channel datapaths (WaveformPlayer and the square/noise players).
- Owns the four channel length counters and drives the chN_on_flag status back to sound_registers. It replaces the free-running clock dividers with clock-enable pulses in one clock domain.

---
 rtl/apu_pkg.sv | 21 ++
 rtl/apu_length_counter.sv | 59 +++++
 rtl/apu_frame_sequencer.sv | 109 ++++++++++
 tb/tb_apu_frame_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants for the APU frame sequencer: step count, full length
// values, the per-step tick masks and the AC'97 prescale value.
package apu_pkg;

  localparam int unsigned FRAME_STEPS   = 8;
  localparam int unsigned STEP_W        = $clog2(FRAME_STEPS);
  localparam int unsigned LEN_FULL_SQ   = 64;
  localparam int unsigned LEN_FULL_WAVE = 256;
  localparam int unsigned PRESCALE_AC97 = 24000;

  // Bit S set means the tick fires on the wrap that leaves step S.
  localparam logic [FRAME_STEPS-1:0] LEN_STEP_MASK   = 8'b0101_0101;
  localparam logic [FRAME_STEPS-1:0] SWEEP_STEP_MASK = 8'b0100_0100;
  localparam logic [FRAME_STEPS-1:0] ENV_STEP_MASK   = 8'b1000_0000;

  function automatic logic step_hit(input logic [FRAME_STEPS-1:0] mask,
                                    input logic [STEP_W-1:0]      step);
    return mask[step];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// One channel's length counter: trigger edge detect, load, decrement on
// length ticks, and the channel-active flag.
module apu_length_counter
  import apu_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned FULL   = LEN_FULL_SQ,
  parameter int unsigned CNT_W  = $clog2(FULL) + 1
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              enable,
  input  logic              trigger,
  input  logic              dont_loop,
  input  logic [DATA_W-1:0] length_data,
  input  logic              dac_enable,
  input  logic              length_tick,
  output logic              on_flag
);

  logic             trig_q, trig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             on_q, on_d;

  always_comb begin
    trig_d = trigger;
    cnt_d  = cnt_q;
    on_d   = on_q;
    if (!enable) begin
      cnt_d = '0;
      on_d  = 1'b0;
    end else if (trigger && !trig_q) begin
      // A trigger on a tick edge takes priority: load only, no decrement.
      cnt_d = CNT_W'(FULL) - CNT_W'(length_data);
      on_d  = dac_enable;
    end else begin
      if (length_tick && dont_loop && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) on_d = 1'b0;
      end
      if (!dac_enable) on_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      trig_q <= trigger;
      cnt_q  <= '0;
      on_q   <= 1'b0;
    end else begin
      trig_q <= trig_d;
      cnt_q  <= cnt_d;
      on_q   <= on_d;
    end
  end

  assign on_flag = on_q;

endmodule

// File: rtl/apu_frame_sequencer.sv
// Frame sequencer: divides the bit clock to the 512 Hz step rate, issues
// length/sweep/envelope enable pulses and owns the four length counters.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_AC97,
  parameter int unsigned PRE_W    = 15
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       sound_master_enable,
  input  logic       ch1_reset,
  input  logic       ch2_reset,
  input  logic       ch3_reset,
  input  logic       ch4_reset,
  input  logic       ch1_dont_loop,
  input  logic       ch2_dont_loop,
  input  logic       ch3_dont_loop,
  input  logic       ch4_dont_loop,
  input  logic [5:0] ch1_length_data,
  input  logic [5:0] ch2_length_data,
  input  logic [7:0] ch3_length_data,
  input  logic [5:0] ch4_length_data,
  input  logic       ch3_enable,
  output logic [2:0] frame_step,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       envelope_tick,
  output logic       ch1_on_flag,
  output logic       ch2_on_flag,
  output logic       ch3_on_flag,
  output logic       ch4_on_flag
);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              len_q, len_d;
  logic              sweep_q, sweep_d;
  logic              env_q, env_d;
  logic              wrap;

  assign wrap = (pre_q == PRE_W'(PRESCALE - 1));

  always_comb begin
    pre_d   = pre_q;
    step_d  = step_q;
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (!sound_master_enable) begin
      pre_d  = '0;
      step_d = '0;
    end else if (wrap) begin
      pre_d   = '0;
      step_d  = step_q + STEP_W'(1);
      len_d   = step_hit(LEN_STEP_MASK, step_q);
      sweep_d = step_hit(SWEEP_STEP_MASK, step_q);
      env_d   = step_hit(ENV_STEP_MASK, step_q);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      pre_q   <= '0;
      step_q  <= '0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      step_q  <= step_d;
      len_q   <= len_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
    end
  end

  assign frame_step    = step_q;
  assign length_tick   = len_q;
  assign sweep_tick    = sweep_q;
  assign envelope_tick = env_q;

  apu_length_counter #(.DATA_W(6), .FULL(LEN_FULL_SQ)) u_len_ch1 (
    .clk(clk), .reset_b(reset_b), .enable(sound_master_enable),
    .trigger(ch1_reset), .dont_loop(ch1_dont_loop), .length_data(ch1_length_data),
    .dac_enable(1'b1), .length_tick(len_q), .on_flag(ch1_on_flag)
  );

  apu_length_counter #(.DATA_W(6), .FULL(LEN_FULL_SQ)) u_len_ch2 (
    .clk(clk), .reset_b(reset_b), .enable(sound_master_enable),
    .trigger(ch2_reset), .dont_loop(ch2_dont_loop), .length_data(ch2_length_data),
    .dac_enable(1'b1), .length_tick(len_q), .on_flag(ch2_on_flag)
  );

  apu_length_counter #(.DATA_W(8), .FULL(LEN_FULL_WAVE)) u_len_ch3 (
    .clk(clk), .reset_b(reset_b), .enable(sound_master_enable),
    .trigger(ch3_reset), .dont_loop(ch3_dont_loop), .length_data(ch3_length_data),
    .dac_enable(ch3_enable), .length_tick(len_q), .on_flag(ch3_on_flag)
  );

  apu_length_counter #(.DATA_W(6), .FULL(LEN_FULL_SQ)) u_len_ch4 (
    .clk(clk), .reset_b(reset_b), .enable(sound_master_enable),
    .trigger(ch4_reset), .dont_loop(ch4_dont_loop), .length_data(ch4_length_data),
    .dac_enable(1'b1), .length_tick(len_q), .on_flag(ch4_on_flag)
  );

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with a 4-cycle prescaler; expected
// values are hand-derived tick positions and length-counter expiries.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       sound_master_enable;
  logic       ch1_reset, ch2_reset, ch3_reset, ch4_reset;
  logic       ch1_dont_loop, ch2_dont_loop, ch3_dont_loop, ch4_dont_loop;
  logic [5:0] ch1_length_data, ch2_length_data, ch4_length_data;
  logic [7:0] ch3_length_data;
  logic       ch3_enable;
  logic [2:0] frame_step;
  logic       length_tick, sweep_tick, envelope_tick;
  logic       ch1_on_flag, ch2_on_flag, ch3_on_flag, ch4_on_flag;

  logic [3:0] flags;
  assign flags = {ch4_on_flag, ch3_on_flag, ch2_on_flag, ch1_on_flag};

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apu_frame_sequencer #(.PRESCALE(4), .PRE_W(3)) dut (
    .clk(clk), .reset_b(reset_b), .sound_master_enable(sound_master_enable),
    .ch1_reset(ch1_reset), .ch2_reset(ch2_reset), .ch3_reset(ch3_reset), .ch4_reset(ch4_reset),
    .ch1_dont_loop(ch1_dont_loop), .ch2_dont_loop(ch2_dont_loop),
    .ch3_dont_loop(ch3_dont_loop), .ch4_dont_loop(ch4_dont_loop),
    .ch1_length_data(ch1_length_data), .ch2_length_data(ch2_length_data),
    .ch3_length_data(ch3_length_data), .ch4_length_data(ch4_length_data),
    .ch3_enable(ch3_enable), .frame_step(frame_step), .length_tick(length_tick),
    .sweep_tick(sweep_tick), .envelope_tick(envelope_tick),
    .ch1_on_flag(ch1_on_flag), .ch2_on_flag(ch2_on_flag),
    .ch3_on_flag(ch3_on_flag), .ch4_on_flag(ch4_on_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_len_tick(input string tag);
    int n = 0;
    while (length_tick !== 1'b1 && n < 32) begin
      step_cycle();
      n++;
    end
    check(tag, 32'(length_tick), 32'd1);
  endtask

  // Returns at the negedge after the edge that consumes the next length tick.
  task automatic after_tick(input string tag);
    wait_len_tick(tag);
    step_cycle();
  endtask

  task automatic pulse(input int ch);
    case (ch)
      1: ch1_reset = 1'b1;
      2: ch2_reset = 1'b1;
      3: ch3_reset = 1'b1;
      default: ch4_reset = 1'b1;
    endcase
    step_cycle();
    ch1_reset = 1'b0;
    ch2_reset = 1'b0;
    ch3_reset = 1'b0;
    ch4_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_v;
    reset_b = 1'b0;
    sound_master_enable = 1'b1;
    ch1_reset = 1'b1;   // held through reset: must not fire afterwards
    ch2_reset = 1'b0; ch3_reset = 1'b0; ch4_reset = 1'b0;
    ch1_dont_loop = 1'b0; ch2_dont_loop = 1'b0; ch3_dont_loop = 1'b0; ch4_dont_loop = 1'b0;
    ch1_length_data = '0; ch2_length_data = '0; ch3_length_data = '0; ch4_length_data = '0;
    ch3_enable = 1'b0;

    repeat (3) step_cycle();
    check("reset_state", 32'({frame_step, length_tick, sweep_tick, envelope_tick, flags}), 32'd0);

    reset_b = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      step_cycle();
      exp_v = {3'((n / 4) % 8), (n % 8 == 4), (n % 16 == 12), (n == 32), 4'b0000};
      check($sformatf("seq_edge%0d", n),
            32'({frame_step, length_tick, sweep_tick, envelope_tick, flags}), 32'(exp_v));
    end

    // ch1: 64-62 = 2 ticks of life
    ch1_reset = 1'b0;
    step_cycle();
    ch1_length_data = 6'd62;
    ch1_dont_loop = 1'b1;
    pulse(1);
    check("ch1_on", 32'(ch1_on_flag), 32'd1);
    after_tick("ch1_tick1");
    check("ch1_after1", 32'(ch1_on_flag), 32'd1);
    after_tick("ch1_tick2");
    check("ch1_after2", 32'(ch1_on_flag), 32'd0);

    // re-trigger while active reloads without dropping the flag
    pulse(1);
    after_tick("ch1r_tick1");
    check("ch1r_mid", 32'(ch1_on_flag), 32'd1);
    pulse(1);
    check("ch1r_retrig", 32'(ch1_on_flag), 32'd1);
    after_tick("ch1r_tick2");
    check("ch1r_after1", 32'(ch1_on_flag), 32'd1);
    after_tick("ch1r_tick3");
    check("ch1r_after2", 32'(ch1_on_flag), 32'd0);

    // ch3: data 0 loads the full 256
    ch3_length_data = 8'd0;
    ch3_dont_loop = 1'b1;
    ch3_enable = 1'b1;
    pulse(3);
    check("ch3_on", 32'(ch3_on_flag), 32'd1);
    for (int i = 1; i <= 255; i++) begin
      after_tick("ch3_tick");
      check($sformatf("ch3_hold%0d", i), 32'(ch3_on_flag), 32'd1);
    end
    after_tick("ch3_tick256");
    check("ch3_expire", 32'(ch3_on_flag), 32'd0);

    // ch2: length disabled holds the count, then runs out the full 64
    ch2_length_data = 6'd0;
    ch2_dont_loop = 1'b0;
    pulse(2);
    check("ch2_on", 32'(ch2_on_flag), 32'd1);
    for (int i = 1; i <= 100; i++) begin
      after_tick("ch2_tick");
      check($sformatf("ch2_loop%0d", i), 32'(ch2_on_flag), 32'd1);
    end
    ch2_dont_loop = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      after_tick("ch2_tick");
      check($sformatf("ch2_hold%0d", i), 32'(ch2_on_flag), 32'd1);
    end
    after_tick("ch2_tick64");
    check("ch2_expire", 32'(ch2_on_flag), 32'd0);

    // ch4: trigger on the tick-consuming edge; load 4 with no decrement
    ch4_length_data = 6'd60;
    ch4_dont_loop = 1'b1;
    wait_len_tick("ch4_align");
    pulse(4);
    check("ch4_on", 32'(ch4_on_flag), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      after_tick("ch4_tick");
      check($sformatf("ch4_hold%0d", i), 32'(ch4_on_flag), 32'd1);
    end
    after_tick("ch4_tick4");
    check("ch4_expire", 32'(ch4_on_flag), 32'd0);

    // ch3_enable gating
    ch1_length_data = 6'd0;
    ch1_dont_loop = 1'b0;
    pulse(1);
    pulse(3);
    check("pre_disable_flags", 32'(flags), 32'h5);
    ch3_enable = 1'b0;
    step_cycle();
    check("ch3_dac_off", 32'(ch3_on_flag), 32'd0);
    pulse(3);
    check("ch3_trig_dac_off", 32'(ch3_on_flag), 32'd0);
    ch3_enable = 1'b1;

    // master disable at step 5
    for (int n = 0; n < 64 && frame_step != 3'd5; n++) step_cycle();
    check("reach_step5", 32'(frame_step), 32'd5);
    sound_master_enable = 1'b0;
    step_cycle();
    check("disable_clear",
          32'({frame_step, length_tick, sweep_tick, envelope_tick, flags}), 32'd0);
    pulse(2);
    check("disable_trig_ignored", 32'(ch2_on_flag), 32'd0);
    step_cycle();
    sound_master_enable = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step_cycle();
      exp_v = (n == 4) ? {3'd1, 1'b1, 1'b0, 1'b0, 4'b0000} : 10'd0;
      check($sformatf("reenable_edge%0d", n),
            32'({frame_step, length_tick, sweep_tick, envelope_tick, flags}), 32'(exp_v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
